fifo_byte_packer: RTL and testbench

Downstream consumer of the byte-wide synchronous FIFO in the tile data path. It pops bytes from the FIFO read port and packs PACK consecutive bytes into one wide word. The word is presented on a valid/ready output toward the tile crossbar. A flush request emits a partially filled word, tagged with its byte count, so the tail of a stream is never stranded. Single clock domain, which is the FIFO read clock.

---
 rtl/fifo_byte_packer_if.sv | 44 ++++
 rtl/fifo_byte_packer.sv | 104 ++++++++++
 tb/tb_fifo_byte_packer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_byte_packer_if.sv
// Bundle of the FIFO read-side and packed-word output signals of fifo_byte_packer.
// The packer drives through the master modport; the FIFO/crossbar side uses slave.
interface fifo_byte_packer_if #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned PACK      = 4,
  parameter int unsigned OUT_WIDTH = IN_WIDTH * PACK,
  parameter int unsigned CW        = $clog2(PACK + 1)
);

  logic                 fifo_empty;
  logic [IN_WIDTH-1:0]  fifo_data;
  logic                 fifo_re;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic [CW-1:0]        out_bytes;
  logic                 out_last;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  flush,
    input  out_ready,
    output fifo_re,
    output out_valid,
    output out_data,
    output out_bytes,
    output out_last
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output flush,
    output out_ready,
    input  fifo_re,
    input  out_valid,
    input  out_data,
    input  out_bytes,
    input  out_last
  );

endinterface

// File: rtl/fifo_byte_packer.sv
// Pops bytes from a synchronous FIFO and packs PACK of them into one wide word,
// presented on valid/ready; a flush closes a partial word tagged with its byte count.
module fifo_byte_packer #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned PACK      = 4,
  parameter int unsigned OUT_WIDTH = IN_WIDTH * PACK,
  parameter int unsigned CW        = $clog2(PACK + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                chip_en,
  fifo_byte_packer_if.master  bus
);

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [OUT_WIDTH-1:0] lanes_q, lanes_d;
  logic [CW-1:0]        out_bytes_q, out_bytes_d;
  logic                 out_last_q, out_last_d;

  logic          fifo_re;
  logic [CW-1:0] count_inc;
  logic          emit_full;
  logic          emit_flush;

  // Gating on rst_n keeps the pop request low for the whole reset window.
  assign fifo_re   = rst_n & chip_en & (state_q == StFill) & ~bus.fifo_empty;
  assign count_inc = count_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    lanes_d     = lanes_q;
    out_bytes_d = out_bytes_q;
    out_last_d  = out_last_q;
    emit_full   = 1'b0;
    emit_flush  = 1'b0;

    if (chip_en) begin
      unique case (state_q)
        StFill: begin
          if (fifo_re) begin
            for (int k = 0; k < int'(PACK); k++) begin
              if (count_q == CW'(k)) begin
                lanes_d[k*IN_WIDTH +: IN_WIDTH] = bus.fifo_data;
              end
            end
            count_d = count_inc;
          end
          emit_full  = fifo_re && (count_inc == CW'(PACK));
          // An empty accumulator with nothing arriving has no tail to emit.
          emit_flush = bus.flush && (fifo_re || (count_q != '0));
          if (emit_full || emit_flush) begin
            state_d     = StHold;
            count_d     = '0;
            out_bytes_d = fifo_re ? count_inc : count_q;
            out_last_d  = emit_flush;
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            state_d     = StFill;
            lanes_d     = '0;
            out_bytes_d = '0;
            out_last_d  = 1'b0;
          end
        end
        default: state_d = StFill;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFill;
      count_q     <= '0;
      lanes_q     <= '0;
      out_bytes_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      lanes_q     <= lanes_d;
      out_bytes_q <= out_bytes_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.fifo_re   = fifo_re;
  assign bus.out_valid = (state_q == StHold);
  assign bus.out_data  = lanes_q;
  assign bus.out_bytes = out_bytes_q;
  assign bus.out_last  = out_last_q;

  // A presented word must not change until the handshake is taken.
  assert property (@(posedge clk) disable iff (!rst_n)
      (bus.out_valid && !(chip_en && bus.out_ready)) |=>
      (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_bytes)));

  assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(PACK));

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Directed bench for fifo_byte_packer: a queue-based FIFO and word model checked every cycle,
// plus literal expectations for the key words.
module tb_fifo_byte_packer;

  localparam int unsigned InW  = 8;
  localparam int unsigned Pack = 4;
  localparam int unsigned OutW = InW * Pack;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chip_en = 1'b1;
  logic fifo_empty = 1'b1;
  logic [InW-1:0] fifo_data = 8'h55;
  logic flush = 1'b0;
  logic out_ready = 1'b0;

  fifo_byte_packer_if #(.IN_WIDTH(InW), .PACK(Pack)) bus ();

  assign bus.fifo_empty = fifo_empty;
  assign bus.fifo_data  = fifo_data;
  assign bus.flush      = flush;
  assign bus.out_ready  = out_ready;

  fifo_byte_packer #(.IN_WIDTH(InW), .PACK(Pack)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .chip_en (chip_en),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int dut_pops = 0;

  logic [InW-1:0] fq[$];
  logic [InW-1:0] collect[$];
  logic            m_valid = 1'b0;
  logic [OutW-1:0] m_data  = '0;
  int              m_bytes = 0;
  logic            m_last  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    collect.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_bytes = 0;
    m_last  = 1'b0;
  endfunction

  // Word-level view: bytes pile up in arrival order until PACK of them or a flush closes a word.
  function automatic void model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!chip_en) return;
    if (!m_valid) begin
      if (!fifo_empty) collect.push_back(fq.pop_front());
      if (collect.size() == Pack || (flush && collect.size() > 0)) begin
        m_data = '0;
        foreach (collect[k]) m_data |= OutW'(collect[k]) << (InW * k);
        m_bytes = collect.size();
        m_last  = flush;
        m_valid = 1'b1;
        collect.delete();
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endfunction

  // The empty flag is only refreshed at an edge, so a push between edges shows up a cycle late.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : 8'h55;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [InW-1:0] b);
    fq.push_back(b);
  endtask

  task automatic run_until_valid(input int budget);
    for (int i = 0; i < budget && !bus.out_valid; i++) tick();
    check("valid_within_budget", 64'(bus.out_valid), 64'(1));
  endtask

  task automatic check_word(input string name, input logic [OutW-1:0] data, input int nb,
                            input logic last);
    check({name, "_data"},  64'(bus.out_data),  64'(data));
    check({name, "_bytes"}, 64'(bus.out_bytes), 64'(nb));
    check({name, "_last"},  64'(bus.out_last),  64'(last));
    check({name, "_model"}, 64'(m_data),        64'(data));
  endtask

  always @(negedge clk) begin
    if (bus.fifo_re) dut_pops++;
    check("fifo_re", 64'(bus.fifo_re),
          64'(rst_n && chip_en && !m_valid && !fifo_empty));
    check("out_valid", 64'(bus.out_valid), 64'(m_valid));
    if (!rst_n) begin
      check("rst_out_data",  64'(bus.out_data),  64'(0));
      check("rst_out_bytes", 64'(bus.out_bytes), 64'(0));
      check("rst_out_last",  64'(bus.out_last),  64'(0));
    end else if (m_valid) begin
      check("out_data",  64'(bus.out_data),  64'(m_data));
      check("out_bytes", 64'(bus.out_bytes), 64'(m_bytes));
      check("out_last",  64'(bus.out_last),  64'(m_last));
    end
  end

  initial begin
    int pops0;
    logic [OutW-1:0] held;

    ticks(2);
    check("reset_valid", 64'(bus.out_valid), 64'(0));
    check("reset_data",  64'(bus.out_data),  64'(0));
    check("reset_re",    64'(bus.fifo_re),   64'(0));
    rst_n = 1'b1;
    tick();

    // Full word with the consumer always ready.
    out_ready = 1'b1;
    pops0 = dut_pops;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    run_until_valid(20);
    check_word("full", 32'h4433_2211, 4, 1'b0);
    check("full_pops", 64'(dut_pops - pops0), 64'(4));
    tick();
    check("full_accepted", 64'(bus.out_valid), 64'(0));

    // Backpressure with more bytes waiting.
    out_ready = 1'b0;
    for (int b = 1; b <= 8; b++) push(InW'(b));
    run_until_valid(20);
    held  = bus.out_data;
    pops0 = dut_pops;
    ticks(10);
    check("bp_pops", 64'(dut_pops - pops0), 64'(0));
    check("bp_stable", 64'(bus.out_data), 64'(held));
    check_word("bp_word1", 32'h0403_0201, 4, 1'b0);
    out_ready = 1'b1;
    tick();
    run_until_valid(20);
    check_word("bp_word2", 32'h0807_0605, 4, 1'b0);
    tick();
    out_ready = 1'b0;

    // Flush of a two-byte tail with the FIFO drained.
    push(8'hAA); push(8'hBB);
    ticks(4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run_until_valid(4);
    check_word("flush2", 32'h0000_BBAA, 2, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Flush with nothing accumulated is dropped.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ticks(3);
    check("flush_empty_ignored", 64'(bus.out_valid), 64'(0));

    // Flush landing on the 3rd capture.
    push(8'hAA); push(8'hBB);
    ticks(4);
    push(8'hCC);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run_until_valid(4);
    check_word("flush3", 32'h00CC_BBAA, 3, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Flush landing on the 4th capture still reports a flushed word.
    push(8'hAA); push(8'hBB); push(8'hCC);
    ticks(5);
    push(8'hDD);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run_until_valid(4);
    check_word("flush4", 32'hDDCC_BBAA, 4, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Enable dropped mid-fill; a flush while disabled is not remembered.
    push(8'h10); push(8'h20);
    ticks(4);
    push(8'h30); push(8'h40);
    chip_en = 1'b0;
    pops0 = dut_pops;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ticks(3);
    check("chip_en_pops", 64'(dut_pops - pops0), 64'(0));
    chip_en = 1'b1;
    run_until_valid(10);
    check_word("chip_en_word", 32'h4030_2010, 4, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset while a word is held: outputs drop at once, stale bytes never reappear.
    push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4); push(8'hE5);
    run_until_valid(20);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.out_valid), 64'(0));
    check("midrst_data",  64'(bus.out_data),  64'(0));
    check("midrst_re",    64'(bus.fifo_re),   64'(0));
    model_reset();
    fq.delete();
    fifo_empty = 1'b1;
    fifo_data  = 8'h55;
    ticks(2);
    rst_n = 1'b1;
    push(8'h5A); push(8'h6B); push(8'h7C); push(8'h8D);
    run_until_valid(20);
    check_word("post_rst", 32'h8D7C_6B5A, 4, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    ticks(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
